// File: rtl/decode_stage_if.sv
// Handshake and sideband signals between fetch, decode and execute.
// The slave modport is the decode stage itself.
interface decode_stage_if #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32
);
  localparam int RS_W = $clog2(NUM_REGS);

  logic              i_valid;
  logic              o_ready;
  logic [31:0]       i_ir;
  logic              o_valid;
  logic              i_ready;
  logic [7:0]        o_opcode;
  logic              o_re1;
  logic [RS_W-1:0]   o_rs1;
  logic              o_re2;
  logic [RS_W-1:0]   o_rs2;
  logic              o_we;
  logic [RS_W-1:0]   o_ws;
  logic [DATA_W-1:0] o_imm;
  logic              o_illegal;
  logic              i_wb_valid;
  logic [RS_W-1:0]   i_wb_sel;
  logic              i_flush;
  logic              o_stall;

  modport slave (
    input  i_valid, i_ir, i_ready, i_wb_valid, i_wb_sel, i_flush,
    output o_ready, o_valid, o_opcode, o_re1, o_rs1, o_re2, o_rs2,
           o_we, o_ws, o_imm, o_illegal, o_stall
  );

  modport master (
    output i_valid, i_ir, i_ready, i_wb_valid, i_wb_sel, i_flush,
    input  o_ready, o_valid, o_opcode, o_re1, o_rs1, o_re2, o_rs2,
           o_we, o_ws, o_imm, o_illegal, o_stall
  );
endinterface

// File: rtl/decode_stage.sv
// Registered, handshaked instruction decode stage with a register scoreboard
// that stalls fetch on RAW/WAW hazards against writes still in flight.
module decode_stage #(
  parameter int NUM_REGS   = 16,
  parameter int DATA_W     = 32,
  parameter bit IMM_SIGNED = 1'b1
) (
  input logic           i_clk,
  input logic           i_reset_n,
  decode_stage_if.slave bus
);
  localparam int RS_W = $clog2(NUM_REGS);

  typedef enum logic [7:0] {
    OP_NOP  = 8'h00,
    OP_LW   = 8'h01,
    OP_SW   = 8'h02,
    OP_ADD  = 8'h03,
    OP_SUB  = 8'h04,
    OP_ADDI = 8'h05
  } opcode_e;

  logic [RS_W-1:0]     rd, ra, fRs1, fRs2;
  logic [DATA_W-1:0]   immExt;
  logic                useImm;
  logic [7:0]          opcode_d, opcode_q;
  logic                re1_d, re1_q, re2_d, re2_q, we_d, we_q;
  logic                illegal_d, illegal_q;
  logic [RS_W-1:0]     rs1_d, rs1_q, rs2_d, rs2_q, ws_d, ws_q;
  logic [DATA_W-1:0]   imm_d, imm_q;
  logic                valid_q;
  logic [NUM_REGS-1:0] sb_d, sb_q;
  logic                outPending, hazard, slotFree, accept, handoff;

  assign rd     = bus.i_ir[20 +: RS_W];
  assign ra     = bus.i_ir[16 +: RS_W];
  assign fRs1   = bus.i_ir[4 +: RS_W];
  assign fRs2   = bus.i_ir[0 +: RS_W];
  assign immExt = IMM_SIGNED ? DATA_W'($signed(bus.i_ir[15:0]))
                             : DATA_W'(bus.i_ir[15:0]);

  always_comb begin
    opcode_d  = bus.i_ir[31:24];
    re1_d     = 1'b0;
    rs1_d     = '0;
    re2_d     = 1'b0;
    rs2_d     = '0;
    we_d      = 1'b0;
    ws_d      = '0;
    useImm    = 1'b0;
    illegal_d = 1'b0;
    case (opcode_e'(bus.i_ir[31:24]))
      OP_NOP: ;
      OP_LW: begin
        we_d   = 1'b1;
        ws_d   = rd;
        useImm = 1'b1;
      end
      OP_SW: begin
        re1_d  = 1'b1;
        rs1_d  = rd;
        useImm = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        re1_d = 1'b1;
        rs1_d = fRs1;
        re2_d = 1'b1;
        rs2_d = fRs2;
        we_d  = 1'b1;
        ws_d  = rd;
      end
      OP_ADDI: begin
        re1_d  = 1'b1;
        rs1_d  = ra;
        we_d   = 1'b1;
        ws_d   = rd;
        useImm = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
    imm_d = useImm ? immExt : '0;
  end

  // A register is busy while its write sits in the scoreboard or in our own output slot.
  assign outPending = valid_q & we_q;
  assign hazard =
      (re1_d & (sb_q[rs1_d] | (outPending & (ws_q == rs1_d)))) |
      (re2_d & (sb_q[rs2_d] | (outPending & (ws_q == rs2_d)))) |
      (we_d  & (sb_q[ws_d]  | (outPending & (ws_q == ws_d))));

  assign slotFree = ~valid_q | bus.i_ready;
  assign handoff  = valid_q & bus.i_ready;
  assign accept   = bus.i_valid & bus.o_ready;

  assign bus.o_ready = slotFree & ~hazard & ~bus.i_flush;
  assign bus.o_stall = bus.i_valid & slotFree & hazard & ~bus.i_flush;

  // The set is applied after the clear so a same-register set/clear keeps the bit.
  always_comb begin
    sb_d = sb_q;
    if (bus.i_wb_valid) sb_d[bus.i_wb_sel] = 1'b0;
    if (handoff && we_q) sb_d[ws_q] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid_q   <= 1'b0;
      sb_q      <= '0;
      opcode_q  <= '0;
      re1_q     <= 1'b0;
      rs1_q     <= '0;
      re2_q     <= 1'b0;
      rs2_q     <= '0;
      we_q      <= 1'b0;
      ws_q      <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
    end else if (bus.i_flush) begin
      valid_q <= 1'b0;
      sb_q    <= '0;
    end else begin
      sb_q <= sb_d;
      if (accept) begin
        valid_q   <= 1'b1;
        opcode_q  <= opcode_d;
        re1_q     <= re1_d;
        rs1_q     <= rs1_d;
        re2_q     <= re2_d;
        rs2_q     <= rs2_d;
        we_q      <= we_d;
        ws_q      <= ws_d;
        imm_q     <= imm_d;
        illegal_q <= illegal_d;
      end else if (handoff) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_valid   = valid_q;
  assign bus.o_opcode  = opcode_q;
  assign bus.o_re1     = re1_q;
  assign bus.o_rs1     = rs1_q;
  assign bus.o_re2     = re2_q;
  assign bus.o_rs2     = rs2_q;
  assign bus.o_we      = we_q;
  assign bus.o_ws      = ws_q;
  assign bus.o_imm     = imm_q;
  assign bus.o_illegal = illegal_q;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized run
// compared against a behavioural model of the decode table and pending-write set.
module tb_decode_stage;
  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  decode_stage_if #(.NUM_REGS(16), .DATA_W(32)) bus ();
  decode_stage_if #(.NUM_REGS(16), .DATA_W(32)) busZ ();

  decode_stage #(.NUM_REGS(16), .DATA_W(32), .IMM_SIGNED(1'b1)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .bus(bus.slave));
  decode_stage #(.NUM_REGS(16), .DATA_W(32), .IMM_SIGNED(1'b0)) dutZ (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .bus(busZ.slave));

  assign busZ.i_valid    = bus.i_valid;
  assign busZ.i_ir       = bus.i_ir;
  assign busZ.i_ready    = bus.i_ready;
  assign busZ.i_wb_valid = bus.i_wb_valid;
  assign busZ.i_wb_sel   = bus.i_wb_sel;
  assign busZ.i_flush    = bus.i_flush;

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0]  op;
    logic        re1;
    logic [3:0]  rs1;
    logic        re2;
    logic [3:0]  rs2;
    logic        we;
    logic [3:0]  ws;
    logic [31:0] imm;
    logic        ill;
  } bundle_t;

  // Model state: registers with a write handed downstream, plus the held instruction.
  bit          pend[16];
  bit          mValid;
  logic [31:0] mIr;

  function automatic bundle_t refDecode(logic [31:0] ir, bit signedImm);
    bundle_t b;
    logic [31:0] imm;
    b = '0;
    b.op = ir[31:24];
    imm = signedImm ? {{16{ir[15]}}, ir[15:0]} : {16'h0000, ir[15:0]};
    case (ir[31:24])
      8'd0: ;
      8'd1: begin b.we = 1; b.ws = ir[23:20]; b.imm = imm; end
      8'd2: begin b.re1 = 1; b.rs1 = ir[23:20]; b.imm = imm; end
      8'd3, 8'd4: begin
        b.re1 = 1; b.rs1 = ir[7:4]; b.re2 = 1; b.rs2 = ir[3:0];
        b.we = 1; b.ws = ir[23:20];
      end
      8'd5: begin b.re1 = 1; b.rs1 = ir[19:16]; b.we = 1; b.ws = ir[23:20]; b.imm = imm; end
      default: b.ill = 1;
    endcase
    return b;
  endfunction

  function automatic bit inFlight(int r);
    bundle_t held;
    held = refDecode(mIr, 1'b1);
    return pend[r] || (mValid && held.we && int'(held.ws) == r);
  endfunction

  function automatic bit blocked(logic [31:0] ir);
    bundle_t b;
    b = refDecode(ir, 1'b1);
    return (b.re1 && inFlight(int'(b.rs1))) || (b.re2 && inFlight(int'(b.rs2))) ||
           (b.we && inFlight(int'(b.ws)));
  endfunction

  function automatic bit expReady();
    return (!mValid || bus.i_ready) && !blocked(bus.i_ir) && !bus.i_flush;
  endfunction

  function automatic bit expStall();
    return bus.i_valid && (!mValid || bus.i_ready) && blocked(bus.i_ir) && !bus.i_flush;
  endfunction

  function automatic bundle_t observed();
    bundle_t b;
    b.op = bus.o_opcode; b.re1 = bus.o_re1; b.rs1 = bus.o_rs1; b.re2 = bus.o_re2;
    b.rs2 = bus.o_rs2; b.we = bus.o_we; b.ws = bus.o_ws; b.imm = bus.o_imm;
    b.ill = bus.o_illegal;
    return b;
  endfunction

  task automatic applyStimulus(bit v, logic [31:0] ir, bit rdy, bit wbv, logic [3:0] wbs, bit fl);
    bus.i_valid = v; bus.i_ir = ir; bus.i_ready = rdy;
    bus.i_wb_valid = wbv; bus.i_wb_sel = wbs; bus.i_flush = fl;
  endtask

  task automatic modelReset();
    foreach (pend[r]) pend[r] = 0;
    mValid = 0;
    mIr = '0;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge; ends on a negedge.
  task automatic tick();
    bit acc, hand;
    bundle_t held;
    acc  = bus.i_valid && expReady();
    hand = mValid && bus.i_ready;
    held = refDecode(mIr, 1'b1);
    @(posedge i_clk);
    if (bus.i_flush) begin
      mValid = 0;
      foreach (pend[r]) pend[r] = 0;
    end else begin
      if (bus.i_wb_valid) pend[bus.i_wb_sel] = 0;
      if (hand && held.we) pend[held.ws] = 1;
      if (acc) begin mValid = 1; mIr = bus.i_ir; end
      else if (hand) mValid = 0;
    end
    @(negedge i_clk);
  endtask

  task automatic doReset();
    applyStimulus(0, '0, 0, 0, '0, 0);
    i_reset_n = 0;
    modelReset();
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1;
  endtask

  task automatic test_reset();
    doReset();
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", bus.o_valid); end
    checks++; if (observed() !== bundle_t'('0)) begin errors++; $display("[TB] FAIL reset_bundle got %h want 0", observed()); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", bus.o_ready); end
  endtask

  task automatic test_reset_midstream();
    doReset();
    applyStimulus(1, 32'h0310_0023, 1, 0, '0, 0); tick();
    applyStimulus(1, 32'h0545_1234, 1, 0, '0, 0); tick();
    applyStimulus(0, 32'h0411_0041, 0, 0, '0, 0);
    #2 i_reset_n = 0;
    #1;
    modelReset();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid got %b want 0", bus.o_valid); end
    checks++; if (observed() !== bundle_t'('0)) begin errors++; $display("[TB] FAIL midreset_bundle got %h want 0", observed()); end
    @(negedge i_clk);
    i_reset_n = 1;
    applyStimulus(1, 32'h0411_0041, 1, 0, '0, 0);
    #1;
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_release_ready got %b want 1", bus.o_ready); end
    checks++; if (bus.o_stall !== 1'b0) begin errors++; $display("[TB] FAIL midreset_release_stall got %b want 0", bus.o_stall); end
    tick();
  endtask

  task automatic test_back_to_back();
    doReset();
    applyStimulus(1, 32'h0310_0023, 1, 0, '0, 0); tick();
    applyStimulus(1, 32'h0545_1234, 1, 0, '0, 0);
    #1;
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_add_valid got %b want 1", bus.o_valid); end
    checks++; if ({bus.o_re1, bus.o_rs1, bus.o_re2, bus.o_rs2, bus.o_we, bus.o_ws} !== {1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 4'd1})
      begin errors++; $display("[TB] FAIL b2b_add_fields got %h want %h", observed(), refDecode(32'h0310_0023, 1)); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready got %b want 1", bus.o_ready); end
    tick();
    applyStimulus(0, '0, 1, 0, '0, 0);
    #1;
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_addi_valid got %b want 1", bus.o_valid); end
    checks++; if (observed() !== refDecode(32'h0545_1234, 1)) begin errors++; $display("[TB] FAIL b2b_addi_bundle got %h want %h", observed(), refDecode(32'h0545_1234, 1)); end
    checks++; if (bus.o_imm !== 32'h0000_1234) begin errors++; $display("[TB] FAIL b2b_addi_imm got %h want 00001234", bus.o_imm); end
    tick();
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain_valid got %b want 0", bus.o_valid); end
  endtask

  task automatic test_raw();
    doReset();
    applyStimulus(1, 32'h0310_0023, 1, 0, '0, 0); tick();
    applyStimulus(1, 32'h0460_0012, 1, 0, '0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if ({bus.o_ready, bus.o_stall} !== 2'b01) begin errors++; $display("[TB] FAIL raw_stall_c%0d got ready/stall %b want 01", c, {bus.o_ready, bus.o_stall}); end
      tick();
    end
    applyStimulus(1, 32'h0460_0012, 1, 1, 4'd1, 0);
    #1;
    checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("[TB] FAIL raw_wb_nobypass got %b want 0", bus.o_ready); end
    tick();
    applyStimulus(1, 32'h0460_0012, 1, 0, '0, 0);
    #1;
    checks++; if ({bus.o_ready, bus.o_stall} !== 2'b10) begin errors++; $display("[TB] FAIL raw_release got ready/stall %b want 10", {bus.o_ready, bus.o_stall}); end
    tick();
    applyStimulus(0, '0, 1, 0, '0, 0);
    #1;
    checks++; if (observed() !== refDecode(32'h0460_0012, 1) || bus.o_valid !== 1'b1)
      begin errors++; $display("[TB] FAIL raw_sub_bundle got %h want %h", observed(), refDecode(32'h0460_0012, 1)); end
    tick();
  endtask

  task automatic test_backpressure();
    doReset();
    applyStimulus(1, 32'h0170_8000, 0, 0, '0, 0); tick();
    applyStimulus(1, 32'h0000_0000, 0, 0, '0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.o_valid !== 1'b1 || bus.o_we !== 1'b1 || bus.o_ws !== 4'd7 || bus.o_opcode !== 8'h01)
        begin errors++; $display("[TB] FAIL bp_hold_c%0d got %h want %h", c, observed(), refDecode(32'h0170_8000, 1)); end
      checks++; if (bus.o_imm !== 32'hFFFF_8000) begin errors++; $display("[TB] FAIL bp_imm_signed got %h want ffff8000", bus.o_imm); end
      checks++; if (busZ.o_imm !== 32'h0000_8000) begin errors++; $display("[TB] FAIL bp_imm_zero got %h want 00008000", busZ.o_imm); end
      checks++; if ({bus.o_ready, bus.o_stall} !== 2'b00) begin errors++; $display("[TB] FAIL bp_ready got ready/stall %b want 00", {bus.o_ready, bus.o_stall}); end
      tick();
    end
    applyStimulus(1, 32'h0000_0000, 1, 0, '0, 0);
    #1;
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release got %b want 1", bus.o_ready); end
    tick();
  endtask

  task automatic test_flush();
    doReset();
    applyStimulus(1, 32'h0310_0024, 1, 0, '0, 0); tick();
    applyStimulus(1, 32'h0535_0007, 1, 0, '0, 0); tick();
    applyStimulus(1, 32'h0190_0010, 1, 0, '0, 0); tick();
    applyStimulus(1, 32'h0380_0013, 1, 1, 4'd1, 1);
    #1;
    checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_accept got %b want 0", bus.o_ready); end
    tick();
    applyStimulus(1, 32'h0380_0013, 1, 0, '0, 0);
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %b want 0", bus.o_valid); end
    checks++; if ({bus.o_ready, bus.o_stall} !== 2'b10) begin errors++; $display("[TB] FAIL flush_sb_clear got ready/stall %b want 10", {bus.o_ready, bus.o_stall}); end
    tick();
    applyStimulus(0, '0, 1, 0, '0, 0);
    #1;
    checks++; if (bus.o_valid !== 1'b1 || observed() !== refDecode(32'h0380_0013, 1))
      begin errors++; $display("[TB] FAIL flush_next_bundle got %h want %h", observed(), refDecode(32'h0380_0013, 1)); end
    tick();
  endtask

  task automatic test_illegal();
    logic [31:0] ir;
    logic [3:0]  r;
    doReset();
    ir = {8'hAA, 24'($urandom)};
    r = ir[23:20];
    applyStimulus(1, ir, 1, 0, '0, 0); tick();
    applyStimulus(0, '0, 1, 0, '0, 0);
    #1;
    checks++; if (bus.o_valid !== 1'b1 || bus.o_illegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal_flag got valid/ill %b%b want 11", bus.o_valid, bus.o_illegal); end
    checks++; if ({bus.o_we, bus.o_re1, bus.o_re2} !== 3'b000 || bus.o_opcode !== 8'hAA)
      begin errors++; $display("[TB] FAIL illegal_bundle got %h want %h", observed(), refDecode(ir, 1)); end
    tick();
    applyStimulus(1, {8'h03, r, 4'h0, 8'h00, r, r}, 1, 0, '0, 0);
    #1;
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("[TB] FAIL illegal_sb_unchanged got %b want 1", bus.o_ready); end
    tick();
  endtask

  task automatic test_random();
    logic [7:0]  op;
    logic [31:0] ir;
    doReset();
    for (int c = 0; c < 400; c++) begin
      op = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(6, 255)) : 8'($urandom_range(0, 5));
      ir = {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 8'($urandom),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      applyStimulus($urandom_range(0, 3) != 0, ir, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 9) < 3, 4'($urandom_range(0, 3)), $urandom_range(0, 31) == 0);
      #1;
      checks++; if (bus.o_valid !== mValid) begin errors++; $display("[TB] FAIL rnd_valid c%0d got %b want %b", c, bus.o_valid, mValid); end
      checks++; if (observed() !== refDecode(mIr, 1)) begin errors++; $display("[TB] FAIL rnd_bundle c%0d got %h want %h", c, observed(), refDecode(mIr, 1)); end
      checks++; if (busZ.o_imm !== refDecode(mIr, 0).imm) begin errors++; $display("[TB] FAIL rnd_imm_zero c%0d got %h want %h", c, busZ.o_imm, refDecode(mIr, 0).imm); end
      checks++; if (bus.o_ready !== expReady()) begin errors++; $display("[TB] FAIL rnd_ready c%0d got %b want %b", c, bus.o_ready, expReady()); end
      checks++; if (bus.o_stall !== expStall()) begin errors++; $display("[TB] FAIL rnd_stall c%0d got %b want %b", c, bus.o_stall, expStall()); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_raw();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
